// File: rtl/lsu_axi_gen_if.sv
// AXI-lite bus bundle between the load/store unit (master) and the memory system (slave).
// Carries the five channels: read address, read data, write address, write data and response.
interface lsu_axi_gen_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic              arvalid;
    logic              arready;
    logic [AW-1:0]     araddr;
    logic [2:0]        arsize;

    logic              rvalid;
    logic              rready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;

    logic              awvalid;
    logic              awready;
    logic [AW-1:0]     awaddr;
    logic [2:0]        awsize;

    logic              wvalid;
    logic              wready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;

    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;

    modport master (
        output arvalid, araddr, arsize,
        input  arready,
        input  rvalid, rdata, rresp,
        output rready,
        output awvalid, awaddr, awsize,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid, bresp,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arsize,
        output arready,
        output rvalid, rdata, rresp,
        input  rready,
        input  awvalid, awaddr, awsize,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid, bresp,
        input  bready
    );
endinterface

// File: rtl/lsu_axi_gen.sv
// Load/store unit front end: turns one RISC-V load or store into a single AXI-lite transaction.
// Ordinary memory gets full-width lane-aligned beats; the narrow device window gets exact sizes.
module lsu_axi_gen #(
    parameter int unsigned   DW           = 32,
    parameter int unsigned   AW           = 32,
    parameter logic [AW-1:0] NARROW_BASE  = AW'(32'h1000_0000),
    parameter logic [AW-1:0] NARROW_LIMIT = AW'(32'h1000_1000)
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_func3,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,

    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,

    lsu_axi_gen_if.master axi
);

    localparam int unsigned NB = DW / 8;
    localparam int unsigned OW = $clog2(NB);
    localparam int unsigned LW = $clog2(DW);

    typedef enum logic [2:0] {
        StIdle,
        StRaddr,
        StRdata,
        StWrite,
        StWresp,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [2:0]    func3_q;
    logic [DW-1:0] wdata_q;

    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          arvalid_q, arvalid_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;

    logic          accept;
    logic [3:0]    req_bytes;
    logic          req_mis;

    logic [1:0]    size;
    logic [3:0]    bytes;
    logic [OW-1:0] offset;
    logic          in_win;
    logic [NB-1:0] byte_mask;
    logic [DW-1:0] lane;
    logic [LW-1:0] msb;
    logic          sign;
    logic [DW-1:0] load_ext;

    assign accept = (state_q == StIdle) && req_valid;

    // Alignment is judged on the live request so a bad access never touches the bus.
    always_comb begin
        req_bytes = 4'd1 << req_func3[1:0];
        req_mis   = ((req_addr[2:0] & 3'(req_bytes - 4'd1)) != 3'd0) || (32'(req_bytes) > NB);
    end

    always_comb begin
        size   = func3_q[1:0];
        bytes  = 4'd1 << size;
        offset = addr_q[OW-1:0];
        in_win = (addr_q >= NARROW_BASE) && (addr_q < NARROW_LIMIT);

        byte_mask = '0;
        for (int i = 0; i < int'(NB); i++) begin
            byte_mask[i] = 32'(i) < 32'(bytes);
        end

        lane = in_win ? axi.rdata : (axi.rdata >> {offset, 3'b000});
        if (32'(bytes) * 32'd8 > DW) begin
            msb = LW'(DW - 1);
        end else begin
            msb = LW'(32'(bytes) * 32'd8 - 32'd1);
        end
        sign = ~func3_q[2] & lane[msb];

        load_ext = '0;
        for (int i = 0; i < int'(DW); i++) begin
            load_ext[i] = (32'(i) <= 32'(msb)) ? lane[i] : sign;
        end
    end

    // Address, size, data and strobes depend only on latched request state, so they stay
    // stable for as long as any valid is held.
    always_comb begin
        if (in_win) begin
            axi.araddr = addr_q;
            axi.arsize = {1'b0, size};
            axi.wdata  = wdata_q;
            axi.wstrb  = byte_mask;
        end else begin
            axi.araddr = {addr_q[AW-1:OW], {OW{1'b0}}};
            axi.arsize = 3'(OW);
            axi.wdata  = wdata_q << {offset, 3'b000};
            axi.wstrb  = byte_mask << offset;
        end
        axi.awaddr = axi.araddr;
        axi.awsize = axi.arsize;
    end

    always_comb begin
        state_d   = state_q;
        arvalid_d = arvalid_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        rdata_d   = rdata_q;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    rdata_d = '0;
                    if (req_mis) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else if (req_we) begin
                        err_d     = 1'b0;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = StWrite;
                    end else begin
                        err_d     = 1'b0;
                        arvalid_d = 1'b1;
                        state_d   = StRaddr;
                    end
                end
            end
            StRaddr: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    state_d   = StRdata;
                end
            end
            StRdata: begin
                if (axi.rvalid) begin
                    rdata_d = load_ext;
                    err_d   = axi.rresp != 2'b00;
                    state_d = StDone;
                end
            end
            StWrite: begin
                // AW and W retire independently; move on once neither is outstanding.
                if (axi.awready) awvalid_d = 1'b0;
                if (axi.wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) state_d = StWresp;
            end
            StWresp: begin
                if (axi.bvalid) begin
                    err_d   = axi.bresp != 2'b00;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            arvalid_q <= arvalid_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            func3_q <= 3'd0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            func3_q <= req_func3;
            wdata_q <= req_wdata;
        end
    end

    // req_ready is masked by rst so that every output reads zero while reset is held.
    assign req_ready  = (state_q == StIdle) && !rst;
    assign resp_valid = state_q == StDone;
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_err   = resp_valid && err_q;

    assign axi.arvalid = arvalid_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.rready  = state_q == StRdata;
    assign axi.bready  = state_q == StWresp;

endmodule

// File: tb/tb_lsu_axi_gen.sv
// Self-checking bench for lsu_axi_gen: directed corner cases plus randomized accesses on a
// 32-bit instance, checked against an arithmetic model, and a directed ld on a 64-bit instance.
module tb_lsu_axi_gen;

    logic clk;
    logic rst;

    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        req64_valid, req64_ready, req64_we;
    logic [2:0]  req64_func3;
    logic [31:0] req64_addr;
    logic [63:0] req64_wdata;
    logic        resp64_valid, resp64_err;
    logic [63:0] resp64_rdata;

    int n_total = 0;
    int n_pass  = 0;

    lsu_axi_gen_if #(.AW(32), .DW(32)) bus ();
    lsu_axi_gen_if #(.AW(32), .DW(64)) bus64 ();

    lsu_axi_gen #(.DW(32), .AW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_func3  (req_func3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .axi        (bus)
    );

    lsu_axi_gen #(.DW(64), .AW(32)) dut64 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req64_valid),
        .req_ready  (req64_ready),
        .req_we     (req64_we),
        .req_func3  (req64_func3),
        .req_addr   (req64_addr),
        .req_wdata  (req64_wdata),
        .resp_valid (resp64_valid),
        .resp_rdata (resp64_rdata),
        .resp_err   (resp64_err),
        .axi        (bus64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_slave();
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    endtask

    // One access on the 32-bit DUT, starting and ending on a falling edge. Delays count
    // cycles a valid (or rready/bready) is seen before the slave answers.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd, input logic [1:0] rsp,
                          input int ar_dly, input int r_dly, input int aw_dly,
                          input int w_dly, input int b_dly, input int rst_cyc);
        int nb, off, exp_lat, resp_cyc;
        bit mis, win, zero_dly, did_rst;
        logic [31:0] exp_addr, exp_wdata, exp_rdata;
        logic [2:0]  exp_size;
        logic [3:0]  exp_strb;
        logic        exp_err;
        longint      lane, mask;
        int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, n_ar, n_aw, n_w, n_resp;

        nb  = 1 << f3[1:0];
        off = int'(addr % 4);
        mis = (addr % nb != 0) || (nb > 4);
        win = (addr >= 32'h1000_0000) && (addr < 32'h1000_1000);
        exp_addr  = win ? addr : (addr & ~32'h3);
        exp_size  = win ? {1'b0, f3[1:0]} : 3'd2;
        exp_wdata = win ? wd : (wd << (8 * off));
        exp_strb  = 4'(((1 << nb) - 1) << (win ? 0 : off));
        exp_rdata = 32'h0;
        if (!mis && !we) begin
            lane = win ? longint'(rd) : longint'(rd >> (8 * off));
            mask = (longint'(1) << (8 * nb)) - 1;
            lane = lane & mask;
            if (!f3[2] && (((lane >> (8 * nb - 1)) & 1) != 0)) lane = lane | ~mask;
            exp_rdata = lane[31:0];
        end
        exp_err  = mis || (rsp != 2'b00);
        exp_lat  = mis ? 1 : 3;
        zero_dly = (ar_dly == 0) && (r_dly == 0) && (aw_dly == 0) && (w_dly == 0) && (b_dly == 0);

        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        n_ar = 0; n_aw = 0; n_w = 0; n_resp = 0; resp_cyc = -1; did_rst = 0;

        req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wd;
        chk("req_ready_idle", req_ready, 1'b1);
        @(negedge clk);
        // Scramble inputs after acceptance; the DUT must use its latched copy.
        req_valid = 1'b0; req_we = 1'($urandom); req_func3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;

        for (int cyc = 1; cyc < 80; cyc++) begin
            if (cyc == 1) chk("busy_not_ready", req_ready, 1'b0);
            if (resp_valid) begin
                n_resp++;
                if (n_resp == 1) begin
                    resp_cyc = cyc;
                    chk("resp_rdata", resp_rdata, exp_rdata);
                    chk("resp_err", resp_err, exp_err);
                end
            end
            if (bus.arvalid) begin
                chk("araddr", bus.araddr, exp_addr);
                chk("arsize", bus.arsize, exp_size);
            end
            if (bus.awvalid) begin
                chk("awaddr", bus.awaddr, exp_addr);
                chk("awsize", bus.awsize, exp_size);
            end
            if (bus.wvalid) begin
                chk("wdata", bus.wdata, exp_wdata);
                chk("wstrb", bus.wstrb, exp_strb);
            end

            if (cyc == rst_cyc) begin
                #2 rst = 1'b1;
                #1 chk("rst_outputs_zero",
                       {req_ready, resp_valid, resp_rdata, resp_err, bus.arvalid, bus.rready,
                        bus.awvalid, bus.wvalid, bus.bready}, 40'h0);
                clear_slave();
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                chk("no_resp_after_rst", resp_valid, 1'b0);
                did_rst = 1;
                break;
            end

            bus.arready = bus.arvalid && (ar_cnt >= ar_dly);
            if (bus.arvalid) ar_cnt++;
            if (bus.arvalid && bus.arready) n_ar++;
            bus.rvalid = bus.rready && (r_cnt >= r_dly);
            if (bus.rready) r_cnt++;
            bus.rdata = bus.rvalid ? rd : $urandom;
            bus.rresp = bus.rvalid ? rsp : 2'($urandom);
            bus.awready = bus.awvalid && (aw_cnt >= aw_dly);
            if (bus.awvalid) aw_cnt++;
            if (bus.awvalid && bus.awready) n_aw++;
            bus.wready = bus.wvalid && (w_cnt >= w_dly);
            if (bus.wvalid) w_cnt++;
            if (bus.wvalid && bus.wready) n_w++;
            bus.bvalid = bus.bready && (b_cnt >= b_dly);
            if (bus.bready) b_cnt++;
            bus.bresp = bus.bvalid ? rsp : 2'($urandom);

            @(negedge clk);
            if (n_resp > 0 && cyc >= resp_cyc + 2) break;
        end
        clear_slave();

        if (!did_rst) begin
            chk("resp_count", n_resp, 1);
            chk("ar_handshakes", n_ar, (!we && !mis) ? 1 : 0);
            chk("aw_handshakes", n_aw, (we && !mis) ? 1 : 0);
            chk("w_handshakes", n_w, (we && !mis) ? 1 : 0);
            if (zero_dly) chk("latency", resp_cyc, exp_lat);
        end
    endtask

    initial begin
        bit got;

        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'd0; req_addr = '0; req_wdata = '0;
        req64_valid = 1'b0; req64_we = 1'b0; req64_func3 = 3'd0; req64_addr = '0;
        req64_wdata = '0;
        clear_slave();
        bus64.arready = 1'b0; bus64.rvalid = 1'b0; bus64.rdata = '0; bus64.rresp = 2'b00;
        bus64.awready = 1'b0; bus64.wready = 1'b0; bus64.bvalid = 1'b0; bus64.bresp = 2'b00;

        #1 rst = 1'b1;
        #2 chk("reset_outputs",
               {req_ready, resp_valid, resp_rdata, resp_err, bus.arvalid, bus.rready,
                bus.awvalid, bus.wvalid, bus.bready}, 40'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // lb, sign-extended from lane 3
        access(1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_FFFF, 2'b00, 0, 0, 0, 0, 0, 0);
        // sh with awready trailing wready by 3 cycles
        access(1'b1, 3'b001, 32'h8000_0002, 32'h0000_1234, 32'h0, 2'b00, 0, 0, 3, 0, 0, 0);
        // sb in the narrow window
        access(1'b1, 3'b000, 32'h1000_0001, 32'h0000_00A5, 32'h0, 2'b00, 0, 0, 0, 0, 0, 0);
        // misaligned lw
        access(1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 0, 0);
        // lbu inside the window reads lane 0 and zero-extends
        access(1'b0, 3'b100, 32'h1000_0003, 32'h0, 32'h1234_5680, 2'b00, 0, 0, 0, 0, 0, 0);
        // window edges
        access(1'b0, 3'b000, 32'h1000_0FFF, 32'h0, 32'h0000_00F0, 2'b00, 0, 0, 0, 0, 0, 0);
        access(1'b0, 3'b000, 32'h1000_1001, 32'h0, 32'h0000_7F00, 2'b00, 1, 2, 0, 0, 0, 0);
        // store with error response, W trailing AW
        access(1'b1, 3'b010, 32'h8000_0010, 32'hCAFE_F00D, 32'h0, 2'b11, 0, 0, 0, 2, 1, 0);
        // reset while waiting in RDATA, then a clean lw
        access(1'b0, 3'b010, 32'h8000_0020, 32'h0, 32'h1111_2222, 2'b00, 0, 100, 0, 0, 0, 3);
        access(1'b0, 3'b010, 32'h8000_0024, 32'h0, 32'h89AB_CDEF, 2'b00, 0, 0, 0, 0, 0, 0);

        for (int t = 0; t < 60; t++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] addr;
            logic [1:0]  rsp;
            we   = 1'($urandom);
            f3   = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
            addr = ($urandom_range(0, 1) == 1) ? 32'h1000_0000 + 32'($urandom_range(0, 32'hFFF))
                                               : 32'h8000_0000 + ($urandom & 32'hFFFF);
            rsp  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            access(we, f3, addr, $urandom, $urandom, rsp,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end

        // 64-bit instance: ld with SLVERR
        bus64.arready = 1'b1;
        req64_valid = 1'b1; req64_we = 1'b0; req64_func3 = 3'b011; req64_addr = 32'h8000_0008;
        chk("ld64_ready", req64_ready, 1'b1);
        @(negedge clk);
        req64_valid = 1'b0;
        got = 0;
        for (int c = 1; c < 20 && !got; c++) begin
            if (bus64.arvalid) begin
                chk("ld64_araddr", bus64.araddr, 32'h8000_0008);
                chk("ld64_arsize", bus64.arsize, 3'd3);
            end
            if (resp64_valid) begin
                chk("ld64_rdata", resp64_rdata, 64'h0123_4567_89AB_CDEF);
                chk("ld64_err", resp64_err, 1'b1);
                got = 1;
            end
            bus64.rvalid = bus64.rready;
            bus64.rdata  = bus64.rready ? 64'h0123_4567_89AB_CDEF : 64'h0;
            bus64.rresp  = 2'b10;
            @(negedge clk);
        end
        chk("ld64_resp_seen", got, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
